// File: rtl/mor1kx_wb_pkg.sv
// ============================================================================
// Module : mor1kx_wb_pkg
// Brief  : Shared Wishbone B3 encodings, FSM state type and burst helpers
//          for the mor1kx CPU-to-Wishbone burst bridge.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mor1kx_wb_pkg;

    localparam logic [2:0] c_cti_classic = 3'b000;
    localparam logic [2:0] c_cti_inc     = 3'b010;
    localparam logic [2:0] c_cti_end     = 3'b111;

    localparam logic [1:0] c_bte_lin     = 2'b00;
    localparam logic [1:0] c_bte_wrap4   = 2'b01;
    localparam logic [1:0] c_bte_wrap8   = 2'b10;
    localparam logic [1:0] c_bte_wrap16  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SINGLE     = 3'd1,
        ST_BURST      = 3'd2,
        ST_RETRY_WAIT = 3'd3,
        ST_GAP        = 3'd4
    } state_t;

    function automatic logic [1:0] bte_for_len(input int bl);
        case (bl)
            4:       return c_bte_wrap4;
            8:       return c_bte_wrap8;
            16:      return c_bte_wrap16;
            default: return c_bte_lin;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mor1kx_wb_wrap_adr.sv
// ============================================================================
// Module : mor1kx_wb_wrap_adr
// Brief  : Next beat address for a wrapping burst; the word index wraps
//          inside the BURST_LENGTH-aligned block.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mor1kx_wb_wrap_adr #(
    parameter int DATA_WIDTH   = 32,
    parameter int BURST_LENGTH = 8
) (
    input  logic [31:0] i_adr,
    output logic [31:0] o_next_adr
);

    localparam int c_off = $clog2(DATA_WIDTH / 8);
    localparam int c_wb  = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;

    generate
        if (BURST_LENGTH > 1) begin : g_wrap
            logic [c_wb-1:0] w_word;
            // Truncated add gives the modulo-BL wrap for free.
            assign w_word     = i_adr[c_off+c_wb-1:c_off] + 1'b1;
            assign o_next_adr = {i_adr[31:c_off+c_wb], w_word, i_adr[c_off-1:0]};
        end else begin : g_lin
            assign o_next_adr = i_adr + 32'(DATA_WIDTH / 8);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/mor1kx_wb_burst_bridge.sv
// ============================================================================
// Module : mor1kx_wb_burst_bridge
// Brief  : CPU bus port to Wishbone B3 master with wrapping bursts and
//          bounded retry. MOR1KX_WB_BRIDGE_STATS_EN adds beat/retry counters.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mor1kx_wb_burst_bridge
    import mor1kx_wb_pkg::*;
#(
    parameter int    DATA_WIDTH   = 32,
    parameter string BUS_IF_TYPE  = "B3_READ_BURSTING",
    parameter int    BURST_LENGTH = 8,
    parameter int    RETRY_DELAY  = 4,
    parameter int    RETRY_LIMIT  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             cpu_adr_i,
    input  logic [DATA_WIDTH-1:0]   cpu_dat_i,
    input  logic                    cpu_req_i,
    input  logic [DATA_WIDTH/8-1:0] cpu_bsel_i,
    input  logic                    cpu_we_i,
    input  logic                    cpu_burst_i,
    output logic                    cpu_ack_o,
    output logic                    cpu_err_o,
    output logic [DATA_WIDTH-1:0]   cpu_dat_o,
    output logic [31:0]             wbm_adr_o,
    output logic                    wbm_stb_o,
    output logic                    wbm_cyc_o,
    output logic [DATA_WIDTH/8-1:0] wbm_sel_o,
    output logic                    wbm_we_o,
    output logic [2:0]              wbm_cti_o,
    output logic [1:0]              wbm_bte_o,
    output logic [DATA_WIDTH-1:0]   wbm_dat_o,
    input  logic                    wbm_ack_i,
    input  logic                    wbm_err_i,
    input  logic                    wbm_rty_i,
    input  logic [DATA_WIDTH-1:0]   wbm_dat_i
`ifdef MOR1KX_WB_BRIDGE_STATS_EN
    ,
    output logic [31:0]             stat_beats_o,
    output logic [31:0]             stat_retries_o
`endif
);

    localparam bit c_rd_burst = (BURST_LENGTH > 1) && (BUS_IF_TYPE != "CLASSIC");
    localparam bit c_wr_burst = (BURST_LENGTH > 1) && (BUS_IF_TYPE == "B3_RW_BURSTING");
    localparam int c_beat_w   = $clog2(BURST_LENGTH + 1);
    localparam int c_retry_w  = $clog2(RETRY_LIMIT + 1);
    localparam int c_wait_w   = $clog2(RETRY_DELAY + 1);
    localparam logic [c_beat_w-1:0]  c_last       = c_beat_w'(BURST_LENGTH - 1);
    localparam logic [c_retry_w-1:0] c_retry_max  = c_retry_w'(RETRY_LIMIT);
    localparam logic [c_wait_w-1:0]  c_wait_last  = c_wait_w'(RETRY_DELAY - 1);

    state_t                r_state, w_state_nxt;
    logic [31:0]           r_adr, w_adr_nxt, w_adr_inc;
    logic                  r_we, w_we_nxt;
    logic                  r_cyc, r_stb, w_cyc_nxt;
    logic [2:0]            r_cti, w_cti_nxt;
    logic [1:0]            r_bte, w_bte_nxt;
    logic [c_beat_w-1:0]   r_beat, w_beat_nxt;
    logic [c_retry_w-1:0]  r_retry, w_retry_nxt;
    logic [c_wait_w-1:0]   r_wait, w_wait_nxt;
    logic                  r_burst, w_burst_nxt;
    logic                  r_err_pulse, w_err_pulse_nxt;
    logic                  w_burst_ok, w_ack;

    mor1kx_wb_wrap_adr #(
        .DATA_WIDTH   (DATA_WIDTH),
        .BURST_LENGTH (BURST_LENGTH)
    ) u_wrap_adr (
        .i_adr      (r_adr),
        .o_next_adr (w_adr_inc)
    );

    assign w_burst_ok = cpu_burst_i & (cpu_we_i ? c_wr_burst : c_rd_burst);

    always_comb begin
        w_state_nxt     = r_state;
        w_adr_nxt       = r_adr;
        w_we_nxt        = r_we;
        w_cyc_nxt       = r_cyc;
        w_cti_nxt       = r_cti;
        w_bte_nxt       = r_bte;
        w_beat_nxt      = r_beat;
        w_retry_nxt     = r_retry;
        w_wait_nxt      = r_wait;
        w_burst_nxt     = r_burst;
        w_err_pulse_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cpu_req_i) begin
                    w_adr_nxt   = cpu_adr_i;
                    w_we_nxt    = cpu_we_i;
                    w_cyc_nxt   = 1'b1;
                    w_beat_nxt  = '0;
                    w_retry_nxt = '0;
                    w_burst_nxt = w_burst_ok;
                    if (w_burst_ok) begin
                        w_state_nxt = ST_BURST;
                        w_cti_nxt   = c_cti_inc;
                        w_bte_nxt   = bte_for_len(BURST_LENGTH);
                    end else begin
                        w_state_nxt = ST_SINGLE;
                        w_cti_nxt   = c_cti_classic;
                        w_bte_nxt   = c_bte_lin;
                    end
                end
            end
            ST_SINGLE, ST_BURST: begin
                if (!cpu_req_i || wbm_err_i) begin
                    w_cyc_nxt   = 1'b0;
                    w_retry_nxt = '0;
                    w_state_nxt = ST_GAP;
                end else if (wbm_ack_i) begin
                    w_retry_nxt = '0;
                    if (r_state == ST_SINGLE || r_beat == c_last) begin
                        w_cyc_nxt   = 1'b0;
                        w_state_nxt = ST_GAP;
                    end else begin
                        w_beat_nxt = r_beat + 1'b1;
                        w_adr_nxt  = w_adr_inc;
                        if (r_beat + 1'b1 == c_last)
                            w_cti_nxt = c_cti_end;
                    end
                end else if (wbm_rty_i) begin
                    w_cyc_nxt = 1'b0;
                    // The limit counts reissues; one more rty escalates.
                    if (r_retry == c_retry_max) begin
                        w_err_pulse_nxt = 1'b1;
                        w_retry_nxt     = '0;
                        w_state_nxt     = ST_GAP;
                    end else begin
                        w_retry_nxt = r_retry + 1'b1;
                        w_wait_nxt  = '0;
                        w_state_nxt = ST_RETRY_WAIT;
                    end
                end
            end
            ST_RETRY_WAIT: begin
                if (!cpu_req_i) begin
                    w_retry_nxt = '0;
                    w_state_nxt = ST_GAP;
                end else if (r_wait == c_wait_last) begin
                    w_cyc_nxt = 1'b1;
                    if (r_burst) begin
                        w_state_nxt = ST_BURST;
                        w_cti_nxt   = (r_beat == c_last) ? c_cti_end : c_cti_inc;
                    end else begin
                        w_state_nxt = ST_SINGLE;
                        w_cti_nxt   = c_cti_classic;
                    end
                end else begin
                    w_wait_nxt = r_wait + 1'b1;
                end
            end
            ST_GAP: begin
                w_cyc_nxt   = 1'b0;
                w_cti_nxt   = c_cti_classic;
                w_bte_nxt   = c_bte_lin;
                w_beat_nxt  = '0;
                w_retry_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_cyc_nxt   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_adr       <= '0;
            r_we        <= 1'b0;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_cti       <= c_cti_classic;
            r_bte       <= c_bte_lin;
            r_beat      <= '0;
            r_retry     <= '0;
            r_wait      <= '0;
            r_burst     <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_adr       <= w_adr_nxt;
            r_we        <= w_we_nxt;
            r_cyc       <= w_cyc_nxt;
            r_stb       <= w_cyc_nxt;
            r_cti       <= w_cti_nxt;
            r_bte       <= w_bte_nxt;
            r_beat      <= w_beat_nxt;
            r_retry     <= w_retry_nxt;
            r_wait      <= w_wait_nxt;
            r_burst     <= w_burst_nxt;
            r_err_pulse <= w_err_pulse_nxt;
        end
    end

    assign w_ack     = wbm_ack_i & r_cyc & cpu_req_i & ~wbm_err_i;
    assign cpu_ack_o = w_ack;
    assign cpu_err_o = (r_cyc & cpu_req_i & wbm_err_i) | r_err_pulse;
    assign cpu_dat_o = wbm_dat_i;
    assign wbm_dat_o = cpu_dat_i;
    assign wbm_sel_o = cpu_bsel_i;
    assign wbm_adr_o = r_adr;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_stb;
    assign wbm_we_o  = r_we;
    assign wbm_cti_o = r_cti;
    assign wbm_bte_o = r_bte;

`ifdef MOR1KX_WB_BRIDGE_STATS_EN
    logic [31:0] r_stat_beats, r_stat_retries;
    logic        w_rty_evt;

    assign w_rty_evt = r_cyc & cpu_req_i & wbm_rty_i & ~wbm_ack_i & ~wbm_err_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_beats   <= '0;
            r_stat_retries <= '0;
        end else begin
            if (w_ack && r_stat_beats != 32'hFFFF_FFFF)
                r_stat_beats <= r_stat_beats + 32'd1;
            if (w_rty_evt && r_stat_retries != 32'hFFFF_FFFF)
                r_stat_retries <= r_stat_retries + 32'd1;
        end
    end

    assign stat_beats_o   = r_stat_beats;
    assign stat_retries_o = r_stat_retries;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mor1kx_wb_burst_bridge.sv
// ============================================================================
// Module : tb_mor1kx_wb_burst_bridge
// Brief  : Directed self-checking bench for mor1kx_wb_burst_bridge
//          (DATA_WIDTH=32, B3_READ_BURSTING, BL=8, RETRY_DELAY=4, RETRY_LIMIT=8).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mor1kx_wb_burst_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_adr_i, cpu_dat_i, cpu_dat_o, wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        cpu_req_i, cpu_we_i, cpu_burst_i, cpu_ack_o, cpu_err_o;
    logic [3:0]  cpu_bsel_i, wbm_sel_o;
    logic        wbm_stb_o, wbm_cyc_o, wbm_we_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic        wbm_ack_i, wbm_err_i, wbm_rty_i;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mor1kx_wb_burst_bridge #(
        .DATA_WIDTH   (32),
        .BUS_IF_TYPE  ("B3_READ_BURSTING"),
        .BURST_LENGTH (8),
        .RETRY_DELAY  (4),
        .RETRY_LIMIT  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_adr_i   (cpu_adr_i),
        .cpu_dat_i   (cpu_dat_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_bsel_i  (cpu_bsel_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_burst_i (cpu_burst_i),
        .cpu_ack_o   (cpu_ack_o),
        .cpu_err_o   (cpu_err_o),
        .cpu_dat_o   (cpu_dat_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_cti_o   (wbm_cti_o),
        .wbm_bte_o   (wbm_bte_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_ack_i   (wbm_ack_i),
        .wbm_err_i   (wbm_err_i),
        .wbm_rty_i   (wbm_rty_i),
        .wbm_dat_i   (wbm_dat_i)
    );

    typedef struct {
        logic [31:0] adr;
        logic [2:0]  cti;
        logic [31:0] rdat;
    } beat_vec_t;

    typedef struct {
        logic [31:0] cdat;
        logic [3:0]  bsel;
        logic [31:0] wdat;
    } pass_vec_t;

    beat_vec_t burst_tbl [8];
    pass_vec_t pass_tbl [3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

`define CHK(n, a, e) chk(n, 64'(a), 64'(e))

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          acks, n, issues, errs;
        logic        prev, saw;
        logic [31:0] last_adr;
        logic [2:0]  last_cti;

        burst_tbl[0] = '{32'h0000_1014, 3'b010, 32'hA000_0000};
        burst_tbl[1] = '{32'h0000_1018, 3'b010, 32'hA000_0011};
        burst_tbl[2] = '{32'h0000_101C, 3'b010, 32'hA000_0022};
        burst_tbl[3] = '{32'h0000_1000, 3'b010, 32'hA000_0033};
        burst_tbl[4] = '{32'h0000_1004, 3'b010, 32'hA000_0044};
        burst_tbl[5] = '{32'h0000_1008, 3'b010, 32'hA000_0055};
        burst_tbl[6] = '{32'h0000_100C, 3'b010, 32'hA000_0066};
        burst_tbl[7] = '{32'h0000_1010, 3'b111, 32'hA000_0077};
        pass_tbl[0]  = '{32'h1234_5678, 4'hF, 32'h8765_4321};
        pass_tbl[1]  = '{32'h0000_00FF, 4'h1, 32'hFFFF_0000};
        pass_tbl[2]  = '{32'hCAFE_F00D, 4'hA, 32'h0BAD_CAFE};

        rst = 1'b1;
        cpu_adr_i = '0; cpu_dat_i = '0; cpu_req_i = 1'b0; cpu_bsel_i = '0;
        cpu_we_i = 1'b0; cpu_burst_i = 1'b0;
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0; wbm_dat_i = '0;
        tick();
        tick();

        // Reset state, with slave ack/err asserted to prove output gating
        wbm_ack_i = 1'b1; wbm_err_i = 1'b1; cpu_req_i = 1'b1;
        #1;
        `CHK("rst_cyc", wbm_cyc_o, 1'b0);
        `CHK("rst_stb", wbm_stb_o, 1'b0);
        `CHK("rst_we", wbm_we_o, 1'b0);
        `CHK("rst_adr", wbm_adr_o, 32'h0);
        `CHK("rst_cti", wbm_cti_o, 3'b000);
        `CHK("rst_bte", wbm_bte_o, 2'b00);
        `CHK("rst_cpu_ack", cpu_ack_o, 1'b0);
        `CHK("rst_cpu_err", cpu_err_o, 1'b0);
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; cpu_req_i = 1'b0;
        rst = 1'b0;
        tick();

        for (int i = 0; i < 3; i++) begin
            cpu_dat_i = pass_tbl[i].cdat; cpu_bsel_i = pass_tbl[i].bsel; wbm_dat_i = pass_tbl[i].wdat;
            #1;
            `CHK($sformatf("pass_wdat%0d", i), wbm_dat_o, pass_tbl[i].cdat);
            `CHK($sformatf("pass_sel%0d", i), wbm_sel_o, pass_tbl[i].bsel);
            `CHK($sformatf("pass_rdat%0d", i), cpu_dat_o, pass_tbl[i].wdat);
        end

        // Single read, two slave wait states
        cpu_adr_i = 32'h2000; cpu_we_i = 1'b0; cpu_burst_i = 1'b0; cpu_req_i = 1'b1;
        tick();
        `CHK("sgl_cyc", wbm_cyc_o, 1'b1);
        `CHK("sgl_stb", wbm_stb_o, 1'b1);
        `CHK("sgl_adr", wbm_adr_o, 32'h2000);
        `CHK("sgl_cti", wbm_cti_o, 3'b000);
        `CHK("sgl_wait1_ack", cpu_ack_o, 1'b0);
        tick();
        `CHK("sgl_wait2_ack", cpu_ack_o, 1'b0);
        tick();
        wbm_ack_i = 1'b1; wbm_dat_i = 32'hDEAD_BEEF;
        #1;
        `CHK("sgl_ack", cpu_ack_o, 1'b1);
        `CHK("sgl_rdat", cpu_dat_o, 32'hDEAD_BEEF);
        tick();
        wbm_ack_i = 1'b0; cpu_req_i = 1'b0;
        `CHK("sgl_gap_cyc", wbm_cyc_o, 1'b0);
        tick();

        // BL=8 wrapping read burst from 0x1014
        cpu_adr_i = 32'h1014; cpu_burst_i = 1'b1; cpu_req_i = 1'b1;
        tick();
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            `CHK($sformatf("bst_adr%0d", i), wbm_adr_o, burst_tbl[i].adr);
            `CHK($sformatf("bst_cti%0d", i), wbm_cti_o, burst_tbl[i].cti);
            `CHK($sformatf("bst_bte%0d", i), wbm_bte_o, 2'b10);
            wbm_ack_i = 1'b1; wbm_dat_i = burst_tbl[i].rdat;
            #1;
            if (cpu_ack_o) acks++;
            `CHK($sformatf("bst_rdat%0d", i), cpu_dat_o, burst_tbl[i].rdat);
            tick();
        end
        wbm_ack_i = 1'b0; cpu_req_i = 1'b0;
        `CHK("bst_acks", acks, 8);
        `CHK("bst_gap_cyc", wbm_cyc_o, 1'b0);
        tick();

        // err (with simultaneous ack) on beat 3, then req held for a back-to-back restart
        cpu_adr_i = 32'h3000; cpu_req_i = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            wbm_ack_i = 1'b1;
            tick();
        end
        `CHK("err_beat3_adr", wbm_adr_o, 32'h300C);
        wbm_err_i = 1'b1;
        #1;
        `CHK("err_cpu_err", cpu_err_o, 1'b1);
        `CHK("err_cpu_ack", cpu_ack_o, 1'b0);
        tick();
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
        `CHK("err_gap_cyc", wbm_cyc_o, 1'b0);
        `CHK("err_gap_err", cpu_err_o, 1'b0);
        tick();
        `CHK("err_idle_cyc", wbm_cyc_o, 1'b0);
        tick();
        `CHK("b2b_cyc", wbm_cyc_o, 1'b1);
        `CHK("b2b_adr", wbm_adr_o, 32'h3000);
        `CHK("b2b_cti", wbm_cti_o, 3'b010);
        // CPU abort: ack arriving after req drops must not reach the CPU
        cpu_req_i = 1'b0; wbm_ack_i = 1'b1;
        #1;
        `CHK("abort_ack", cpu_ack_o, 1'b0);
        tick();
        wbm_ack_i = 1'b0;
        `CHK("abort_cyc", wbm_cyc_o, 1'b0);
        tick();

        // Single rty on beat 0
        cpu_adr_i = 32'h4000; cpu_req_i = 1'b1;
        tick();
        wbm_rty_i = 1'b1;
        #1;
        `CHK("rty1_ack", cpu_ack_o, 1'b0);
        tick();
        wbm_rty_i = 1'b0;
        n = 0;
        while (!wbm_cyc_o && n < 20) begin
            n++;
            tick();
        end
        `CHK("rty1_low_cycles", n, 4);
        `CHK("rty1_adr", wbm_adr_o, 32'h4000);
        `CHK("rty1_cti", wbm_cti_o, 3'b010);
        `CHK("rty1_stb", wbm_stb_o, 1'b1);
        acks = 0;
        for (int k = 0; k < 20 && wbm_cyc_o; k++) begin
            wbm_ack_i = 1'b1;
            #1;
            if (cpu_ack_o) acks++;
            tick();
        end
        wbm_ack_i = 1'b0; cpu_req_i = 1'b0;
        `CHK("rty1_acks", acks, 8);
        tick();

        // Endless rty: 8 reissues then one error pulse
        cpu_adr_i = 32'h5000; cpu_burst_i = 1'b0; cpu_req_i = 1'b1; wbm_rty_i = 1'b1;
        prev = 1'b0; issues = 0; errs = 0; saw = 1'b0;
        for (int k = 0; k < 200 && !saw; k++) begin
            tick();
            if (wbm_cyc_o && !prev) issues++;
            prev = wbm_cyc_o;
            if (cpu_err_o) begin
                saw = 1'b1;
                errs++;
                `CHK("rtyx_err_cyc", wbm_cyc_o, 1'b0);
                cpu_req_i = 1'b0;
            end
        end
        `CHK("rtyx_err_seen", saw, 1'b1);
        `CHK("rtyx_reissues", issues - 1, 8);
        for (int k = 0; k < 5; k++) begin
            tick();
            if (cpu_err_o) errs++;
        end
        `CHK("rtyx_err_pulses", errs, 1);
        `CHK("rtyx_idle_cyc", wbm_cyc_o, 1'b0);
        wbm_rty_i = 1'b0;

        // Reset on beat 5, then a fresh burst starting at beat 0
        cpu_adr_i = 32'h6000; cpu_burst_i = 1'b1; cpu_req_i = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            wbm_ack_i = 1'b1;
            tick();
        end
        wbm_ack_i = 1'b0;
        `CHK("rstm_beat5_adr", wbm_adr_o, 32'h6014);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        `CHK("rstm_cyc", wbm_cyc_o, 1'b0);
        `CHK("rstm_stb", wbm_stb_o, 1'b0);
        `CHK("rstm_cti", wbm_cti_o, 3'b000);
        `CHK("rstm_adr", wbm_adr_o, 32'h0);
        cpu_adr_i = 32'h7004;
        tick();
        `CHK("rstm_new_adr", wbm_adr_o, 32'h7004);
        `CHK("rstm_new_cti", wbm_cti_o, 3'b010);
        acks = 0; last_adr = '0; last_cti = '0;
        for (int k = 0; k < 20 && wbm_cyc_o; k++) begin
            last_adr = wbm_adr_o; last_cti = wbm_cti_o;
            wbm_ack_i = 1'b1;
            #1;
            if (cpu_ack_o) acks++;
            tick();
        end
        wbm_ack_i = 1'b0; cpu_req_i = 1'b0;
        `CHK("rstm_new_acks", acks, 8);
        `CHK("rstm_last_adr", last_adr, 32'h7000);
        `CHK("rstm_last_cti", last_cti, 3'b111);
        tick();

        // Write burst request is issued as a single in a read-bursting bridge
        cpu_adr_i = 32'h8000; cpu_we_i = 1'b1; cpu_burst_i = 1'b1; cpu_req_i = 1'b1;
        cpu_dat_i = 32'h1357_9BDF; cpu_bsel_i = 4'hC;
        tick();
        `CHK("wr_we", wbm_we_o, 1'b1);
        `CHK("wr_cti", wbm_cti_o, 3'b000);
        `CHK("wr_bte", wbm_bte_o, 2'b00);
        `CHK("wr_dat", wbm_dat_o, 32'h1357_9BDF);
        `CHK("wr_sel", wbm_sel_o, 4'hC);
        wbm_ack_i = 1'b1;
        #1;
        `CHK("wr_ack", cpu_ack_o, 1'b1);
        tick();
        wbm_ack_i = 1'b0; cpu_req_i = 1'b0;
        `CHK("wr_gap_cyc", wbm_cyc_o, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

`undef CHK

endmodule

`default_nettype wire

// File: doc/mor1kx_wb_burst_bridge.md
Name: mor1kx_wb_burst_bridge

Overview:
Parametrised CPU-to-Wishbone B3 master bridge. It is the next generation of the per-port bus bridge used by the stand-alone pipeline tops. Over the existing bridge it adds:
- generalised data width;
- burst lengths 1/4/8/16;
- write bursting;
- bounded retry handling with error escalation.
One instance sits between each CPU bus port (ibus/dbus) and its external Wishbone master.

Parameters:
DATA_WIDTH, 32, Wishbone/CPU data width (32 or 64); sel width = DATA_WIDTH/8
BUS_IF_TYPE, "B3_READ_BURSTING", "CLASSIC" | "B3_READ_BURSTING" | "B3_RW_BURSTING"
BURST_LENGTH, 8, beats per cache-line burst (1, 4, 8, 16)
RETRY_DELAY, 4, idle cycles between rty and reissue (>=1)
RETRY_LIMIT, 8, consecutive retries before error escalation (>=1)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous active-high reset
cpu_adr_i  in  32  byte address of request
cpu_dat_i  in  DATA_WIDTH  write data
cpu_req_i  in  1  request, held until ack/err
cpu_bsel_i  in  DATA_WIDTH/8  byte select
cpu_we_i  in  1  write
cpu_burst_i  in  1  burst (cache-line) request
cpu_ack_o  out  1  beat acknowledged
cpu_err_o  out  1  transfer error
cpu_dat_o  out  DATA_WIDTH  read data
wbm_adr_o  out  32  WB address
wbm_stb_o  out  1  WB strobe
wbm_cyc_o  out  1  WB cycle
wbm_sel_o  out  DATA_WIDTH/8  WB select
wbm_we_o  out  1  WB write enable
wbm_cti_o  out  3  cycle type
wbm_bte_o  out  2  burst type
wbm_dat_o  out  DATA_WIDTH  WB write data
wbm_ack_i  in  1  WB ack
wbm_err_i  in  1  WB error
wbm_rty_i  in  1  WB retry
wbm_dat_i  in  DATA_WIDTH  WB read data

Behaviour:
- Reset (sync, rst=1): state IDLE; cyc/stb/we=0, adr=0, cti=000, bte=00, beat and retry counters 0. cpu_ack_o/cpu_err_o are 0 because they are gated by cyc.
- Registered outputs: adr/cyc/stb/we/cti/bte. Combinational passthrough: wbm_dat_o=cpu_dat_i, wbm_sel_o=cpu_bsel_i, cpu_dat_o=wbm_dat_i.
- cpu_ack_o = wbm_ack_i & wbm_cyc_o & cpu_req_i & ~wbm_err_i.
- cpu_err_o = wbm_cyc_o & cpu_req_i & wbm_err_i, plus a one-cycle pulse on retry exhaustion.
- Burst eligibility: BURST_LENGTH>1 & cpu_burst_i, and either (!cpu_we_i & type != CLASSIC) or (cpu_we_i & type == B3_RW_BURSTING).
- FSM states: IDLE, SINGLE, BURST, RETRY_WAIT, GAP.
- IDLE: on cpu_req_i, latch adr/we; next cycle cyc=stb=1 (request-to-stb latency 1).
  - If burst-eligible → BURST: cti=010, bte=01/10/11 for BL 4/8/16, beat counter 0.
  - Otherwise → SINGLE: cti=000.
- SINGLE: ack → GAP.
- BURST: each ack increments the beat counter. Address increments by DATA_WIDTH/8 and wraps within the BL-beat aligned block (low log2(BL) word bits modulo BL).
  - When the next beat is the last, cti=111.
  - Ack on the last beat → GAP.
- Priority in any active state: err > ack > rty.
  - err: drop cyc/stb next cycle → GAP. Retry counter cleared.
  - rty: drop cyc/stb → RETRY_WAIT. Retry counter +1.
- RETRY_WAIT: wait RETRY_DELAY cycles, then reissue at the current beat address, re-entering SINGLE or BURST. A remaining burst restarts with cti=010, or cti=111 if only one beat remains.
  - If the retry counter reaches RETRY_LIMIT: pulse cpu_err_o one cycle (ungated) → GAP.
  - Any ack clears the retry counter.
- CPU abort (cpu_req_i low while cyc=1): acks are not forwarded; cyc/stb drop next cycle → GAP.
- GAP: one cycle with cyc=stb=0 → IDLE. A req still high in IDLE starts a new transfer. Back-to-back spacing is therefore ≥2 idle WB cycles between transfers.
- Reset mid-transfer: cyc/stb fall in the cycle after rst sampled high; the transfer is not resumed.
- Write bursts: CPU presents the next beat's data/sel in the cycle after cpu_ack_o.

Optional Feature:
MOR1KX_WB_BRIDGE_STATS_EN
- Defined: adds output ports stat_beats_o[31:0] (acked beats) and stat_retries_o[31:0] (rty events). Both are saturating at 32'hFFFFFFFF and reset to 0.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Decomposition:
Shared package mor1kx_wb_pkg holds:
- CTI constants: CLASSIC=000, INC=010, END=111.
- BTE encodings: LIN=00, WRAP4=01, WRAP8=10, WRAP16=11.
- FSM state typedef.
- Function bte_for_len(BL).

One sub-module: mor1kx_wb_wrap_adr, the combinational wrap-address incrementer (adr, BL, DATA_WIDTH) → next adr.

Test Plan:
- Single read, CLASSIC, adr 0x2000, slave ack after 2 waits, dat 0xDEADBEEF → cti=000, one cpu_ack_o with cpu_dat_o=0xDEADBEEF, then GAP cycle with cyc=0.
- BL=8 read burst from 0x1014 → wbm_adr_o sequence 0x1014,1018,101C,1000,1004,1008,100C,1010; bte=10; cti=010 ×7 then 111; 8 cpu_ack_o.
- err on beat 3 of an 8-beat burst → cpu_err_o=1 that cycle, no cpu_ack_o, cyc=0 next cycle, FSM→GAP→IDLE.
- rty once on beat 0 (RETRY_DELAY=4) → cyc low exactly 4 cycles, reissue at the same adr; transfer completes normally.
- Slave rty forever, RETRY_LIMIT=8 → 8 reissues, then a single cpu_err_o pulse, cyc stays 0 in GAP.
- rst asserted on beat 5 of a burst → cyc/stb/cti/adr all 0 next cycle; a new request after reset starts at beat 0.
